// File: rtl/parallel_operand_loader.sv
// Assembles two full-width operands from a narrow chunk stream (LSB chunk first)
// and presents them as a registered, stable pair under a valid/ready handshake.
module parallel_operand_loader #(
    parameter int S = 3,
    parameter int C = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic [2**C-1:0] chunk,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [2**S-1:0] in1,
    output logic [2**S-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int W  = 2**S;
    localparam int K  = 2**C;
    localparam int N  = 2**(S-C);
    localparam int CW = (S == C) ? 1 : S - C;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [W-1:0]    in1_q,   in1_d;
    logic [W-1:0]    in2_q,   in2_d;
    logic            rdy_q;
    logic            accept;

    function automatic logic [W-1:0] insert_chunk(input logic [W-1:0] word,
                                                  input logic [CW-1:0] idx,
                                                  input logic [K-1:0] data);
        for (int i = 0; i < N; i++) begin
            if (idx == CW'(i)) word[i*K +: K] = data;
        end
        return word;
    endfunction

    // rdy_q keeps in_ready low until the first clock after reset release.
    assign in_ready  = rdy_q & (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign in1       = in1_q;
    assign in2       = in2_q;
    assign accept    = in_valid & in_ready & ~clr;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        in1_d   = in1_q;
        in2_d   = in2_q;

        if (clr) begin
            state_d = LOAD_A;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        in1_d = insert_chunk(in1_q, cnt_q, chunk);
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = LOAD_B;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        in2_d = insert_chunk(in2_q, cnt_q, chunk);
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule
